mu0_regfile: RTL and testbench
==============================

// Module: mu0_regfile
// PURPOSE
//  Parametrised multi-register bank for the next-generation MU0 datapath; replaces
//  individual enable-load registers (ACC, PC, IR, temps) with one addressed array.
//  One write port, two registered read ports with write-through bypass, and a
//  per-register pending scoreboard so the control FSM can stall reads of stale data.
// PARAMETERS
//  WIDTH   16  data width of every register (>=1)
//  ADDR_W  2   address width; DEPTH = 2**ADDR_W registers (localparam)
// PORTS
//  Clk       in   1       rising-edge clock
//  Reset     in   1       asynchronous, active-low reset (0 = reset)
//  WrEn      in   1       write strobe
//  WrAddr    in   ADDR_W  write address
//  WrData    in   WIDTH   write data
//  ClaimEn   in   1       mark ClaimAddr pending (result in flight)
//  ClaimAddr in   ADDR_W  register being claimed
//  RdEnA     in   1       read port A request
//  RdAddrA   in   ADDR_W  read port A address
//  QA        out  WIDTH   read port A data (registered)
//  ValidA    out  1       QA holds committed, non-pending data
//  RdEnB/RdAddrB/QB/ValidB  as port A, independent
//  Pending   out  DEPTH   pending bit per register (bit i = register i)
// BEHAVIOUR
//  - Reset low (async): all registers, QA, QB = 0; ValidA, ValidB = 0; Pending = 0.
//    Held low mid-operation: all state cleared immediately; no write completes.
//  - Write: at rising Clk with WrEn=1, reg[WrAddr] <= WrData; Pending[WrAddr] cleared.
//  - Claim: at rising Clk with ClaimEn=1, Pending[ClaimAddr] set.
//  - Claim and write, same address, same edge: data written, Pending stays 1
//    (new producer supersedes). Different addresses: both take effect.
//  - Read latency 1 cycle. At rising Clk with RdEnA=1:
//      QA <= (WrEn && WrAddr==RdAddrA) ? WrData : reg[RdAddrA]   (bypass)
//      ValidA <= ~Pending_w[RdAddrA], where Pending_w = Pending with this edge's
//      write clear applied but NOT this edge's claim.
//    RdEnA=0: QA holds its value, ValidA <= 0. Port B identical, independent.
//  - Both ports may read the same address on the same edge; both get same data.
//  - Pending is a registered output; it reflects state after the last edge.
//  - Address arithmetic: no wrap issues; all addresses in range by construction.
// CONFIGURATION
//  MU0_REGFILE_ZERO_REG_EN
//   defined: register 0 is constant zero; writes to address 0 are discarded,
//     claims of address 0 ignored, Pending[0] always 0; reads of 0 return 0 with
//     Valid=1 (bypass never applies to address 0).
//   undefined: register 0 is an ordinary register, same as all others.
// TESTING  (WIDTH=16, ADDR_W=2)
//  - Reset=0 mid-stream after writes -> QA=QB=0, ValidA=ValidB=0, Pending=4'b0000
//    asynchronously; first reads after release of reg1 return 16'h0000, Valid=1.
//  - Write 16'hBEEF to reg2, next cycle RdEnA=1 RdAddrA=2 -> one cycle later
//    QA=16'hBEEF, ValidA=1; RdEnA=0 next cycle -> QA holds BEEF, ValidA=0.
//  - Same-cycle WrEn=1 WrAddr=3 WrData=16'h1234 and RdEnB=1 RdAddrB=3 -> next
//    cycle QB=16'h1234 (bypass), ValidB=1.
//  - ClaimEn addr1 -> Pending=4'b0010; read addr1 -> ValidA=0; write 16'h00AA
//    to reg1 with read same edge -> QA=16'h00AA, ValidA=1, Pending=4'b0000.
//  - ClaimEn and WrEn both addr2 same edge -> reg2 updated, Pending[2]=1,
//    following read of addr2 gives ValidA=0.
//  - With MU0_REGFILE_ZERO_REG_EN: write 16'hFFFF + claim addr0 -> read addr0
//    gives QA=16'h0000, ValidA=1, Pending[0]=0; without macro: QA=16'hFFFF,
//    Pending[0]=1 after the edge.

Source files
------------

// File: rtl/mu0_regfile_if.sv
// Register bank bus for mu0_regfile: one write port, one claim port,
// two read ports and the per-register pending vector.
interface mu0_regfile_if #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 2
);
   localparam int DEPTH = 2**ADDR_W;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [WIDTH-1:0]  wr_data;
   logic              claim_en;
   logic [ADDR_W-1:0] claim_addr;
   logic              rd_en_a;
   logic [ADDR_W-1:0] rd_addr_a;
   logic [WIDTH-1:0]  q_a;
   logic              valid_a;
   logic              rd_en_b;
   logic [ADDR_W-1:0] rd_addr_b;
   logic [WIDTH-1:0]  q_b;
   logic              valid_b;
   logic [DEPTH-1:0]  pending;

   modport master (
      output wr_en, wr_addr, wr_data, claim_en, claim_addr,
             rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
      input  q_a, valid_a, q_b, valid_b, pending
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, claim_en, claim_addr,
             rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
      output q_a, valid_a, q_b, valid_b, pending
   );
endinterface

// File: rtl/mu0_regfile.sv
// MU0 register bank: 1 write port, 2 registered read ports (1-cycle, write bypass), pending scoreboard; no backpressure.
// Optional MU0_REGFILE_ZERO_REG_EN makes register 0 a constant zero that cannot be written or claimed.
module mu0_regfile #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 2
) (
   input logic          clk,
   input logic          rst_n,
   mu0_regfile_if.slave rf
);
   localparam int DEPTH = 2**ADDR_W;

   logic [WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0] pending_q;
   logic [WIDTH-1:0] q_a_q, q_b_q;
   logic             valid_a_q, valid_b_q;

   logic             wr_eff, claim_eff;
   logic [DEPTH-1:0] pend_clr, pend_set, pend_w, pend_nxt;
   logic [WIDTH-1:0] rd_data_a, rd_data_b;

`ifdef MU0_REGFILE_ZERO_REG_EN
   // Gating at the strobes keeps reg 0 at its reset value and its pending bit clear.
   assign wr_eff    = rf.wr_en    && (rf.wr_addr    != '0);
   assign claim_eff = rf.claim_en && (rf.claim_addr != '0);
`else
   assign wr_eff    = rf.wr_en;
   assign claim_eff = rf.claim_en;
`endif

   always_comb begin
      pend_clr = '0;
      pend_set = '0;
      if (wr_eff)
         pend_clr[rf.wr_addr] = 1'b1;
      if (claim_eff)
         pend_set[rf.claim_addr] = 1'b1;
   end

   // Read validity sees this edge's write clear but not this edge's claim.
   assign pend_w   = pending_q & ~pend_clr;
   assign pend_nxt = pend_w | pend_set;

   assign rd_data_a = (wr_eff && rf.wr_addr == rf.rd_addr_a) ? rf.wr_data : regs[rf.rd_addr_a];
   assign rd_data_b = (wr_eff && rf.wr_addr == rf.rd_addr_b) ? rf.wr_data : regs[rf.rd_addr_b];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            regs[i] <= '0;
         pending_q <= '0;
         q_a_q     <= '0;
         q_b_q     <= '0;
         valid_a_q <= 1'b0;
         valid_b_q <= 1'b0;
      end else begin
         if (wr_eff)
            regs[rf.wr_addr] <= rf.wr_data;
         pending_q <= pend_nxt;

         if (rf.rd_en_a) begin
            q_a_q     <= rd_data_a;
            valid_a_q <= ~pend_w[rf.rd_addr_a];
         end else begin
            valid_a_q <= 1'b0;
         end

         if (rf.rd_en_b) begin
            q_b_q     <= rd_data_b;
            valid_b_q <= ~pend_w[rf.rd_addr_b];
         end else begin
            valid_b_q <= 1'b0;
         end
      end
   end

   assign rf.q_a     = q_a_q;
   assign rf.valid_a = valid_a_q;
   assign rf.q_b     = q_b_q;
   assign rf.valid_b = valid_b_q;
   assign rf.pending = pending_q;
endmodule

// File: tb/tb_mu0_regfile.sv
// Randomized + directed bench for mu0_regfile against an array-based reference model.
module tb_mu0_regfile;
`ifdef MU0_REGFILE_ZERO_REG_EN
   localparam bit ZR = 1'b1;
`else
   localparam bit ZR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   mu0_regfile_if #(.WIDTH(16), .ADDR_W(2)) bus ();
   mu0_regfile #(.WIDTH(16), .ADDR_W(2)) dut (.clk(clk), .rst_n(rst_n), .rf(bus));

   // Reference state: register contents, pending flags, read outputs.
   logic [15:0] m_reg [4] = '{16'h0, 16'h0, 16'h0, 16'h0};
   bit   [3:0]  m_pend = '0;
   logic [15:0] m_qa = '0, m_qb = '0;
   bit          m_va = 1'b0, m_vb = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_edge();
      bit we, ce;
      bit [3:0] pw;
      we = bus.wr_en && !(ZR && bus.wr_addr == 2'd0);
      ce = bus.claim_en && !(ZR && bus.claim_addr == 2'd0);
      pw = m_pend;
      if (we) pw[bus.wr_addr] = 1'b0;
      if (bus.rd_en_a) begin
         m_qa = (we && bus.wr_addr == bus.rd_addr_a) ? bus.wr_data : m_reg[bus.rd_addr_a];
         m_va = !pw[bus.rd_addr_a];
      end else m_va = 1'b0;
      if (bus.rd_en_b) begin
         m_qb = (we && bus.wr_addr == bus.rd_addr_b) ? bus.wr_data : m_reg[bus.rd_addr_b];
         m_vb = !pw[bus.rd_addr_b];
      end else m_vb = 1'b0;
      if (we) m_reg[bus.wr_addr] = bus.wr_data;
      m_pend = pw;
      if (ce) m_pend[bus.claim_addr] = 1'b1;
   endtask

   always @(posedge clk) if (rst_n) model_edge();

   always @(negedge rst_n) begin
      for (int i = 0; i < 4; i++) m_reg[i] = '0;
      m_pend = '0; m_qa = '0; m_qb = '0; m_va = 1'b0; m_vb = 1'b0;
   end

   always @(negedge clk) begin
      chk("model_qa", {16'h0, bus.q_a}, {16'h0, m_qa});
      chk("model_va", {31'h0, bus.valid_a}, {31'h0, m_va});
      chk("model_qb", {16'h0, bus.q_b}, {16'h0, m_qb});
      chk("model_vb", {31'h0, bus.valid_b}, {31'h0, m_vb});
      chk("model_pend", {28'h0, bus.pending}, {28'h0, m_pend});
   end

   task automatic idle();
      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.claim_en = 1'b0; bus.claim_addr = '0;
      bus.rd_en_a = 1'b0; bus.rd_addr_a = '0;
      bus.rd_en_b = 1'b0; bus.rd_addr_b = '0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_qa"}, {16'h0, bus.q_a}, 32'h0);
      chk({tag, "_qb"}, {16'h0, bus.q_b}, 32'h0);
      chk({tag, "_va"}, {31'h0, bus.valid_a}, 32'h0);
      chk({tag, "_vb"}, {31'h0, bus.valid_b}, 32'h0);
      chk({tag, "_pend"}, {28'h0, bus.pending}, 32'h0);
   endtask

   task automatic mid_reset(input string tag);
      rst_n = 1'b0;
      #1;
      check_all_zero(tag);
      bus.wr_en = 1'b1; bus.wr_addr = 2'd1; bus.wr_data = 16'h7777;
      bus.claim_en = 1'b1; bus.claim_addr = 2'd2;
      cyc();
      check_all_zero({tag, "_held"});
      rst_n = 1'b1;
      idle();
   endtask

   initial begin
      idle();
      #1;
      check_all_zero("reset");
      #1 rst_n = 1'b1;

      // Write then read back, then drop the read enable.
      bus.wr_en = 1'b1; bus.wr_addr = 2'd2; bus.wr_data = 16'hBEEF;
      cyc();
      idle(); bus.rd_en_a = 1'b1; bus.rd_addr_a = 2'd2;
      cyc();
      chk("rd_qa", {16'h0, bus.q_a}, 32'h0000BEEF);
      chk("rd_va", {31'h0, bus.valid_a}, 32'h1);
      idle();
      cyc();
      chk("hold_qa", {16'h0, bus.q_a}, 32'h0000BEEF);
      chk("hold_va", {31'h0, bus.valid_a}, 32'h0);

      // Same-edge write/read bypass on port B.
      bus.wr_en = 1'b1; bus.wr_addr = 2'd3; bus.wr_data = 16'h1234;
      bus.rd_en_b = 1'b1; bus.rd_addr_b = 2'd3;
      cyc();
      chk("byp_qb", {16'h0, bus.q_b}, 32'h00001234);
      chk("byp_vb", {31'h0, bus.valid_b}, 32'h1);

      // Claim, stale read, then completing write with same-edge read.
      idle(); bus.claim_en = 1'b1; bus.claim_addr = 2'd1;
      cyc();
      chk("claim_pend", {28'h0, bus.pending}, 32'h2);
      idle(); bus.rd_en_a = 1'b1; bus.rd_addr_a = 2'd1;
      cyc();
      chk("stale_va", {31'h0, bus.valid_a}, 32'h0);
      bus.wr_en = 1'b1; bus.wr_addr = 2'd1; bus.wr_data = 16'h00AA;
      cyc();
      chk("fill_qa", {16'h0, bus.q_a}, 32'h000000AA);
      chk("fill_va", {31'h0, bus.valid_a}, 32'h1);
      chk("fill_pend", {28'h0, bus.pending}, 32'h0);

      // Claim and write to the same register on the same edge.
      idle(); bus.claim_en = 1'b1; bus.claim_addr = 2'd2;
      bus.wr_en = 1'b1; bus.wr_addr = 2'd2; bus.wr_data = 16'h5555;
      cyc();
      chk("cw_pend", {28'h0, bus.pending}, 32'h4);
      idle(); bus.rd_en_a = 1'b1; bus.rd_addr_a = 2'd2;
      cyc();
      chk("cw_qa", {16'h0, bus.q_a}, 32'h00005555);
      chk("cw_va", {31'h0, bus.valid_a}, 32'h0);

      // Register 0 write + claim.
      idle(); bus.claim_en = 1'b1; bus.claim_addr = 2'd0;
      bus.wr_en = 1'b1; bus.wr_addr = 2'd0; bus.wr_data = 16'hFFFF;
      cyc();
      idle(); bus.rd_en_a = 1'b1; bus.rd_addr_a = 2'd0;
      cyc();
      chk("r0_qa", {16'h0, bus.q_a}, ZR ? 32'h0 : 32'h0000FFFF);
      chk("r0_va", {31'h0, bus.valid_a}, ZR ? 32'h1 : 32'h0);
      chk("r0_pend", {28'h0, bus.pending}, ZR ? 32'h4 : 32'h5);

      // Asynchronous reset mid-stream, then reg1 reads back as zero.
      mid_reset("mreset");
      bus.rd_en_a = 1'b1; bus.rd_addr_a = 2'd1;
      bus.rd_en_b = 1'b1; bus.rd_addr_b = 2'd1;
      cyc();
      chk("post_qa", {16'h0, bus.q_a}, 32'h0);
      chk("post_va", {31'h0, bus.valid_a}, 32'h1);
      chk("post_qb", {16'h0, bus.q_b}, 32'h0);
      chk("post_vb", {31'h0, bus.valid_b}, 32'h1);

      // Random traffic checked by the model every cycle.
      for (int n = 0; n < 2000; n++) begin
         if (n == 700 || n == 1400) mid_reset("rreset");
         bus.wr_en      = ($urandom_range(0, 1) == 1);
         bus.wr_addr    = 2'($urandom_range(0, 3));
         bus.wr_data    = 16'($urandom);
         bus.claim_en   = ($urandom_range(0, 9) < 3);
         bus.claim_addr = 2'($urandom_range(0, 3));
         bus.rd_en_a    = ($urandom_range(0, 9) < 7);
         bus.rd_addr_a  = 2'($urandom_range(0, 3));
         bus.rd_en_b    = ($urandom_range(0, 9) < 7);
         bus.rd_addr_b  = ($urandom_range(0, 3) == 0) ? bus.rd_addr_a : 2'($urandom_range(0, 3));
         cyc();
      end
      idle();
      cyc();
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
